// File: rtl/soc_wb_copy_master.sv
// Wishbone classic copy engine: reads LEN words from a source window
// and writes them to a destination window, one word at a time.
`timescale 1ns/1ps
module soc_wb_copy_master #(
    parameter int AW        = 32,
    parameter int DW        = 32,
    parameter int LW        = 16,
    parameter int RETRY_MAX = 3,
    parameter int TIMEOUT   = 255
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start_i,
    input  logic [AW-1:0] src_adr_i,
    input  logic [AW-1:0] dst_adr_i,
    input  logic [LW-1:0] len_i,
    output logic          busy_o,
    output logic          done_o,
    output logic [1:0]    err_code_o,
    output logic [LW-1:0] words_done_o,
    output logic [AW-1:0] wbm_adr_o,
    output logic [DW-1:0] wbm_dat_o,
    output logic [3:0]    wbm_sel_o,
    output logic          wbm_we_o,
    output logic          wbm_cyc_o,
    output logic          wbm_stb_o,
    input  logic [DW-1:0] wbm_dat_i,
    input  logic          wbm_ack_i,
    input  logic          wbm_err_i,
    input  logic          wbm_rty_i
);

    localparam int TW = $clog2(TIMEOUT + 1);
    localparam int RW = $clog2(RETRY_MAX + 2);
    localparam logic [TW-1:0] TO_LAST = TW'(TIMEOUT - 1);
    localparam logic [RW-1:0] RT_LAST = RW'(RETRY_MAX);

    localparam logic [1:0] ERR_OK  = 2'd0;
    localparam logic [1:0] ERR_BUS = 2'd1;
    localparam logic [1:0] ERR_RTY = 2'd2;
    localparam logic [1:0] ERR_TO  = 2'd3;

    typedef enum logic [2:0] {
        S_IDLE,
        S_RD,
        S_RD_GAP,
        S_WR,
        S_WR_GAP,
        S_FIN
    } state_t;

    state_t        state_q, state_d;
    logic [AW-1:0] src_q, src_d;
    logic [AW-1:0] dst_q, dst_d;
    logic [LW-1:0] len_q, len_d;
    logic [DW-1:0] buf_q, buf_d;
    logic [LW-1:0] words_q, words_d;
    logic [1:0]    err_q, err_d;
    logic [RW-1:0] rty_q, rty_d;
    logic [TW-1:0] to_q, to_d;
    logic          again_q, again_d;

    logic          cyc_q, cyc_d;
    logic          stb_q, stb_d;
    logic          we_q, we_d;
    logic [3:0]    sel_q, sel_d;
    logic [AW-1:0] adr_q, adr_d;
    logic [DW-1:0] dat_q, dat_d;
    logic          busy_q, busy_d;
    logic          done_q, done_d;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= S_IDLE;
            src_q   <= '0;
            dst_q   <= '0;
            len_q   <= '0;
            buf_q   <= '0;
            words_q <= '0;
            err_q   <= ERR_OK;
            rty_q   <= '0;
            to_q    <= '0;
            again_q <= 1'b0;
            cyc_q   <= 1'b0;
            stb_q   <= 1'b0;
            we_q    <= 1'b0;
            sel_q   <= 4'h0;
            adr_q   <= '0;
            dat_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            src_q   <= src_d;
            dst_q   <= dst_d;
            len_q   <= len_d;
            buf_q   <= buf_d;
            words_q <= words_d;
            err_q   <= err_d;
            rty_q   <= rty_d;
            to_q    <= to_d;
            again_q <= again_d;
            cyc_q   <= cyc_d;
            stb_q   <= stb_d;
            we_q    <= we_d;
            sel_q   <= sel_d;
            adr_q   <= adr_d;
            dat_q   <= dat_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    always_comb begin
        state_d = state_q;
        src_d   = src_q;
        dst_d   = dst_q;
        len_d   = len_q;
        buf_d   = buf_q;
        words_d = words_q;
        err_d   = err_q;
        rty_d   = rty_q;
        to_d    = to_q;
        again_d = again_q;
        unique case (state_q)
            S_IDLE: begin
                if (start_i) begin
                    err_d   = ERR_OK;
                    words_d = '0;
                    rty_d   = '0;
                    to_d    = '0;
                    again_d = 1'b0;
                    if (len_i != '0) begin
                        src_d   = {src_adr_i[AW-1:2], 2'b00};
                        dst_d   = {dst_adr_i[AW-1:2], 2'b00};
                        len_d   = len_i;
                        state_d = S_RD;
                    end else begin
                        state_d = S_FIN;
                    end
                end
            end
            S_RD, S_WR: begin
                if (wbm_err_i) begin
                    err_d   = ERR_BUS;
                    state_d = S_FIN;
                end else if (wbm_ack_i) begin
                    rty_d   = '0;
                    to_d    = '0;
                    again_d = 1'b0;
                    if (state_q == S_RD) begin
                        buf_d   = wbm_dat_i;
                        state_d = S_RD_GAP;
                    end else begin
                        words_d = words_q + LW'(1);
                        state_d = S_WR_GAP;
                    end
                end else if (wbm_rty_i) begin
                    if (rty_q == RT_LAST) begin
                        err_d   = ERR_RTY;
                        state_d = S_FIN;
                    end else begin
                        // Gap state with again set reissues the same access
                        rty_d   = rty_q + RW'(1);
                        again_d = 1'b1;
                        state_d = (state_q == S_RD) ? S_RD_GAP : S_WR_GAP;
                    end
                end else if (to_q == TO_LAST) begin
                    err_d   = ERR_TO;
                    state_d = S_FIN;
                end else begin
                    to_d = to_q + TW'(1);
                end
            end
            S_RD_GAP: begin
                again_d = 1'b0;
                state_d = again_q ? S_RD : S_WR;
            end
            S_WR_GAP: begin
                again_d = 1'b0;
                if (again_q) begin
                    state_d = S_WR;
                end else begin
                    src_d   = src_q + AW'(4);
                    dst_d   = dst_q + AW'(4);
                    state_d = (words_q == len_q) ? S_FIN : S_RD;
                end
            end
            S_FIN: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Bus outputs are decoded from the next state so they come out of flops
    always_comb begin
        cyc_d  = 1'b0;
        stb_d  = 1'b0;
        we_d   = 1'b0;
        sel_d  = 4'h0;
        adr_d  = adr_q;
        dat_d  = '0;
        busy_d = 1'b0;
        done_d = 1'b0;
        unique case (state_d)
            S_RD: begin
                cyc_d  = 1'b1;
                stb_d  = 1'b1;
                sel_d  = 4'hF;
                adr_d  = src_d;
                busy_d = 1'b1;
            end
            S_WR: begin
                cyc_d  = 1'b1;
                stb_d  = 1'b1;
                we_d   = 1'b1;
                sel_d  = 4'hF;
                adr_d  = dst_d;
                dat_d  = buf_d;
                busy_d = 1'b1;
            end
            S_RD_GAP, S_WR_GAP: begin
                busy_d = 1'b1;
            end
            S_FIN: begin
                done_d = 1'b1;
            end
            default: begin
                busy_d = 1'b0;
            end
        endcase
    end

    assign busy_o       = busy_q;
    assign done_o       = done_q;
    assign err_code_o   = err_q;
    assign words_done_o = words_q;
    assign wbm_adr_o    = adr_q;
    assign wbm_dat_o    = dat_q;
    assign wbm_sel_o    = sel_q;
    assign wbm_we_o     = we_q;
    assign wbm_cyc_o    = cyc_q;
    assign wbm_stb_o    = stb_q;

endmodule
